eth_tx_manchester: RTL and testbench

- 10BASE-T transmit path, the counterpart of the Ethernet receive input.
- Accepts frame bytes over a valid/ready byte stream.
- Prepends the 7-byte preamble and the SFD, Manchester-encodes LSB-first, and ends each frame with the end-of-transmission delimiter (ETD).
- Enforces the inter-frame gap and emits normal link pulses (NLP) while idle. Output drives the LVDS/TX pad buffer in the top level, clocked by CLK_MAIN.

---
 rtl/eth_tx_manchester.sv | 227 ++++++++++++++++++++++
 tb/tb_eth_tx_manchester.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_manchester.sv
// eth_tx_manchester: 10BASE-T transmit path.
//
// Takes frame bytes over a valid/ready byte stream and sends the preamble, the SFD and then the
// frame data. Data is Manchester-encoded LSB first, where 1 is sent as low->high. Each frame ends
// with the end-of-transmission delimiter (line held high), followed by the inter-frame gap.
// Normal link pulses are sent while the line is idle.
//
// Ports:
//   CLK       main clock
//   RST       asynchronous, active-high reset
//   in_data   frame byte (destination MAC first, FCS supplied upstream)
//   in_valid  in_data/in_last are valid
//   in_last   current byte is the final byte of the frame
//   in_ready  byte accepted this cycle when in_valid=1 (high only at a load point)
//   tx_out    line level, 1 = positive differential
//   tx_oe     driver enable, 0 = differential-zero idle
//   busy      high from frame start through the end of the inter-frame gap
//   underrun  one-cycle pulse when a frame is truncated for missing data
module eth_tx_manchester #(
    parameter int unsigned HALF_BIT_CLKS   = 5,
    parameter int unsigned PREAMBLE_BYTES  = 7,
    parameter int unsigned IFG_BITS        = 96,
    parameter int unsigned ETD_BITS        = 2,
    parameter int unsigned NLP_PERIOD_CLKS = 1600000,
    parameter int unsigned NLP_WIDTH_CLKS  = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx_out,
    output logic       tx_oe,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned ETD_CLKS  = ETD_BITS * 2 * HALF_BIT_CLKS;
    localparam int unsigned IFG_CLKS  = IFG_BITS * 2 * HALF_BIT_CLKS;
    localparam int unsigned GAP_MAX_A = (ETD_CLKS > IFG_CLKS) ? ETD_CLKS : IFG_CLKS;
    localparam int unsigned GAP_MAX   = (GAP_MAX_A > NLP_WIDTH_CLKS) ? GAP_MAX_A : NLP_WIDTH_CLKS;
    localparam int unsigned CLK_W     = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam int unsigned GAP_W     = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
    localparam int unsigned NLP_W     = (NLP_PERIOD_CLKS > 1) ? $clog2(NLP_PERIOD_CLKS) : 1;
    localparam int unsigned PRE_W     = (PREAMBLE_BYTES > 1) ? $clog2(PREAMBLE_BYTES) : 1;

    localparam logic [CLK_W-1:0] CLK_LAST    = CLK_W'(HALF_BIT_CLKS - 1);
    localparam logic [CLK_W-1:0] CLK_PRE     = CLK_W'((HALF_BIT_CLKS > 1) ? HALF_BIT_CLKS - 2 : 0);
    localparam logic [GAP_W-1:0] ETD_LAST    = GAP_W'(ETD_CLKS - 1);
    localparam logic [GAP_W-1:0] IFG_LAST    = GAP_W'(IFG_CLKS - 1);
    localparam logic [GAP_W-1:0] NLP_LAST    = GAP_W'(NLP_WIDTH_CLKS - 1);
    localparam logic [NLP_W-1:0] PERIOD_LAST = NLP_W'(NLP_PERIOD_CLKS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(PREAMBLE_BYTES - 1);
    localparam logic [7:0]       PRE_BYTE    = 8'h55;
    localparam logic [7:0]       SFD_BYTE    = 8'hD5;

    typedef enum logic [2:0] {
        StIdle, StNlp, StPreamble, StSfd, StData, StEtd, StIfg
    } state_e;

    state_e           state_q;
    logic [CLK_W-1:0] clk_cnt_q;   // clocks within the current half-bit
    logic [3:0]       half_q;      // half-bit index within the current byte
    logic [PRE_W-1:0] pre_cnt_q;
    logic [7:0]       data_q;
    logic             last_q;
    logic [GAP_W-1:0] gap_q;       // shared by NLP width, ETD and IFG timing
    logic [NLP_W-1:0] nlp_cnt_q;

    logic [7:0] cur_byte;
    logic [3:0] half_nxt;
    logic       half_tick;
    logic       byte_end;
    logic       pre_end;
    logic       load_at_end;
    logic       next_level;

    always_comb begin
        cur_byte = data_q;
        if (state_q == StPreamble) begin
            cur_byte = PRE_BYTE;
        end else if (state_q == StSfd) begin
            cur_byte = SFD_BYTE;
        end
    end

    assign half_tick   = (clk_cnt_q == CLK_LAST);
    assign byte_end    = half_tick && (half_q == 4'd15);
    // True one clock before byte_end, so in_ready can be registered onto the load-point cycle.
    assign pre_end     = (HALF_BIT_CLKS > 1) ? ((half_q == 4'd15) && (clk_cnt_q == CLK_PRE))
                                             : (half_q == 4'd14);
    assign load_at_end = (state_q == StSfd) || ((state_q == StData) && !last_q);
    assign half_nxt    = half_q + 4'd1;
    assign next_level  = half_nxt[0] ? cur_byte[half_nxt[3:1]] : ~cur_byte[half_nxt[3:1]];

    // Byte-position counters are always zero outside PREAMBLE/SFD/DATA (they wrap to zero at
    // every byte end, and frames only leave those states at a byte end), so frame start only
    // has to set the state and the first half-bit level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            half_q    <= '0;
            pre_cnt_q <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            gap_q     <= '0;
            nlp_cnt_q <= '0;
            in_ready  <= 1'b0;
            tx_out    <= 1'b0;
            tx_oe     <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            in_ready <= 1'b0;
            underrun <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q   <= StPreamble;
                        busy      <= 1'b1;
                        tx_oe     <= 1'b1;
                        tx_out    <= ~PRE_BYTE[0];
                        nlp_cnt_q <= '0;
                    end else if (nlp_cnt_q == PERIOD_LAST) begin
                        state_q   <= StNlp;
                        tx_oe     <= 1'b1;
                        tx_out    <= 1'b1;
                        gap_q     <= '0;
                        nlp_cnt_q <= '0;
                    end else begin
                        nlp_cnt_q <= nlp_cnt_q + 1'b1;
                    end
                end
                StNlp: begin
                    if (gap_q == NLP_LAST) begin
                        gap_q     <= '0;
                        nlp_cnt_q <= '0;
                        // A frame that arrived during the pulse starts as soon as it ends.
                        if (in_valid) begin
                            state_q <= StPreamble;
                            busy    <= 1'b1;
                            tx_out  <= ~PRE_BYTE[0];
                        end else begin
                            state_q <= StIdle;
                            tx_oe   <= 1'b0;
                            tx_out  <= 1'b0;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                StPreamble, StSfd, StData: begin
                    if (!half_tick) begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end else begin
                        clk_cnt_q <= '0;
                        half_q    <= half_nxt;
                        if (!byte_end) begin
                            tx_out <= next_level;
                        end
                    end
                    if (pre_end && load_at_end) begin
                        in_ready <= 1'b1;
                    end
                    if (byte_end) begin
                        if (state_q == StPreamble) begin
                            if (pre_cnt_q == PRE_LAST) begin
                                state_q   <= StSfd;
                                pre_cnt_q <= '0;
                                tx_out    <= ~SFD_BYTE[0];
                            end else begin
                                pre_cnt_q <= pre_cnt_q + 1'b1;
                                tx_out    <= ~PRE_BYTE[0];
                            end
                        end else if (load_at_end && in_valid) begin
                            state_q <= StData;
                            data_q  <= in_data;
                            last_q  <= in_last;
                            tx_out  <= ~in_data[0];
                        end else begin
                            // Either the last byte is done or upstream ran dry at a load point.
                            underrun <= load_at_end;
                            state_q  <= StEtd;
                            tx_out   <= 1'b1;
                            gap_q    <= '0;
                        end
                    end
                end
                StEtd: begin
                    if (gap_q == ETD_LAST) begin
                        state_q <= StIfg;
                        tx_oe   <= 1'b0;
                        tx_out  <= 1'b0;
                        gap_q   <= '0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                StIfg: begin
                    if (gap_q == IFG_LAST) begin
                        gap_q <= '0;
                        // A pending frame follows the gap directly; busy never drops.
                        if (in_valid) begin
                            state_q <= StPreamble;
                            tx_oe   <= 1'b1;
                            tx_out  <= ~PRE_BYTE[0];
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_oe   <= 1'b0;
                    tx_out  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_manchester.sv
// tb_eth_tx_manchester: directed bench for eth_tx_manchester with HALF_BIT_CLKS=2,
// NLP_PERIOD_CLKS=200 and NLP_WIDTH_CLKS=3. One bit is 4 clocks, preamble+SFD is 256 clocks,
// each data byte is 32 clocks, ETD is 8 clocks and the IFG is 384 clocks.
module tb_eth_tx_manchester;

    localparam int HBC = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       tx_out;
    logic       tx_oe;
    logic       busy;
    logic       underrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] fb [0:3];

    eth_tx_manchester #(
        .HALF_BIT_CLKS  (2),
        .NLP_PERIOD_CLKS(200),
        .NLP_WIDTH_CLKS (3)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_last (in_last),
        .in_ready(in_ready),
        .tx_out  (tx_out),
        .tx_oe   (tx_oe),
        .busy    (busy),
        .underrun(underrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Same, for "first bad cycle" values where -1 means no bad cycle.
    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Runs one frame of n bytes from fb[], of which only ns are ever offered (ns<n: underrun).
    // pre_armed: in_valid/in_data are already set and the next edge starts the frame.
    // chain: after the last byte, keep in_valid high with the next frame's first byte.
    task automatic send_frame(input string tag, input int n, input int ns, input bit pre_armed,
                              input bit chain, input logic [7:0] chain_byte,
                              input logic chain_last);
        int t_data_end;
        int t_etd_end;
        int t_total;
        int n_pts;
        int idx;
        int h;
        int b;
        int n_rdy;
        int n_urun;
        int bad_out;
        int bad_oe;
        int bad_busy;
        int bad_rdy;
        int bad_urun;
        bit rdy_prev;
        logic [7:0] byte_v;
        logic bitv;
        logic exp_out;
        logic exp_oe;
        logic exp_rdy;
        logic exp_urun;
        t_data_end = 256 + 32 * ns;
        t_etd_end  = t_data_end + 8;
        t_total    = t_etd_end + 384;
        n_pts      = (ns < n) ? ns + 1 : n;
        idx        = 0;
        n_rdy      = 0;
        n_urun     = 0;
        bad_out    = -1;
        bad_oe     = -1;
        bad_busy   = -1;
        bad_rdy    = -1;
        bad_urun   = -1;
        rdy_prev   = 1'b0;
        if (!pre_armed) begin
            in_valid = 1'b1;
            in_data  = fb[0];
            in_last  = (n == 1);
        end
        for (int k = 0; k < t_total; k++) begin
            @(posedge CLK);
            #1;
            // The edge just passed consumed a byte if in_ready was high before it.
            if (rdy_prev && idx < ns) begin
                idx++;
                if (idx < ns) begin
                    in_data = fb[idx];
                    in_last = (idx == n - 1);
                end else if (idx == n && chain) begin
                    in_data = chain_byte;
                    in_last = chain_last;
                end else begin
                    in_valid = 1'b0;
                    in_data  = 8'hFF;
                    in_last  = 1'b0;
                end
            end
            exp_oe = (k < t_etd_end);
            if (k < t_data_end) begin
                h = k / HBC;
                b = h / 16;
                if (b < 7) byte_v = 8'h55;
                else if (b == 7) byte_v = 8'hD5;
                else byte_v = fb[b - 8];
                bitv    = byte_v[(h % 16) / 2];
                exp_out = (h % 2 == 1) ? bitv : ~bitv;
            end else begin
                exp_out = (k < t_etd_end);
            end
            exp_rdy  = (k >= 255) && ((k - 255) % 32 == 0) && ((k - 255) / 32 < n_pts);
            exp_urun = (ns < n) && (k == t_data_end);
            if (tx_out !== exp_out && bad_out < 0) bad_out = k;
            if (tx_oe !== exp_oe && bad_oe < 0) bad_oe = k;
            if (busy !== 1'b1 && bad_busy < 0) bad_busy = k;
            if (in_ready !== exp_rdy && bad_rdy < 0) bad_rdy = k;
            if (underrun !== exp_urun && bad_urun < 0) bad_urun = k;
            if (in_ready === 1'b1) n_rdy++;
            if (underrun === 1'b1) n_urun++;
            rdy_prev = (in_ready === 1'b1);
        end
        check_int({tag, " tx_out first bad cycle"}, bad_out, -1);
        check_int({tag, " tx_oe first bad cycle"}, bad_oe, -1);
        check_int({tag, " busy first bad cycle"}, bad_busy, -1);
        check_int({tag, " in_ready first bad cycle"}, bad_rdy, -1);
        check_int({tag, " in_ready pulses"}, n_rdy, n_pts);
        check_int({tag, " underrun first bad cycle"}, bad_urun, -1);
        check_int({tag, " underrun pulses"}, n_urun, (ns < n) ? 1 : 0);
        if (!chain) begin
            @(posedge CLK);
            #1;
            check({tag, " busy after ifg"}, busy, 0);
            check({tag, " tx_oe after ifg"}, tx_oe, 0);
        end
    endtask

    initial begin
        int bad;
        logic exp;
        RST      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        #1 RST = 1'b1;
        #1;
        check("reset tx_out", tx_out, 0);
        check("reset tx_oe", tx_oe, 0);
        check("reset busy", busy, 0);
        check("reset in_ready", in_ready, 0);
        check("reset underrun", underrun, 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // Link pulses at edges 200, 403, 606 after release, 3 clocks each. A frame requested
        // mid-way through the third pulse starts as soon as it ends (edge 609).
        bad = -1;
        for (int e = 1; e <= 608; e++) begin
            @(posedge CLK);
            #1;
            exp = ((e >= 200) && (e <= 202)) || ((e >= 403) && (e <= 405)) || (e >= 606);
            if ((tx_oe !== exp || tx_out !== exp || busy !== 1'b0) && bad < 0) bad = e;
            if (e == 200) check("nlp1 start tx_oe", tx_oe, 1);
            if (e == 203) check("nlp1 end tx_oe", tx_oe, 0);
            if (e == 403) check("nlp2 start tx_out", tx_out, 1);
            if (e == 607) begin
                in_valid = 1'b1;
                in_data  = 8'h3C;
                in_last  = 1'b1;
            end
        end
        check_int("nlp train first bad edge", bad, -1);
        fb[0] = 8'h3C;
        send_frame("after_nlp", 1, 1, 1'b1, 1'b0, 8'h00, 1'b0);

        fb[0] = 8'hA5;
        send_frame("single_a5", 1, 1, 1'b0, 1'b0, 8'h00, 1'b0);

        fb[0] = 8'h01;
        fb[1] = 8'h02;
        fb[2] = 8'h03;
        send_frame("three_byte", 3, 3, 1'b0, 1'b0, 8'h00, 1'b0);

        fb[0] = 8'h11;
        fb[1] = 8'h22;
        send_frame("b2b_first", 2, 2, 1'b0, 1'b1, 8'hC3, 1'b1);
        fb[0] = 8'hC3;
        send_frame("b2b_second", 1, 1, 1'b1, 1'b0, 8'h00, 1'b0);

        fb[0] = 8'h77;
        fb[1] = 8'h88;
        send_frame("underrun", 2, 1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset at the second load point of a 2-byte frame (DATA state, in_ready high).
        in_valid = 1'b1;
        in_data  = 8'h96;
        in_last  = 1'b0;
        repeat (257) @(posedge CLK);
        #1;
        in_data = 8'h69;
        in_last = 1'b1;
        repeat (31) @(posedge CLK);
        #1;
        check("pre-reset in_ready", in_ready, 1);
        check("pre-reset tx_oe", tx_oe, 1);
        in_valid = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("mid-frame reset tx_out", tx_out, 0);
        check("mid-frame reset tx_oe", tx_oe, 0);
        check("mid-frame reset busy", busy, 0);
        check("mid-frame reset in_ready", in_ready, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        bad = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge CLK);
            #1;
            exp = (e == 200);
            if ((tx_oe !== exp || busy !== 1'b0) && bad < 0) bad = e;
        end
        check_int("post-reset nlp first bad edge", bad, -1);
        check("post-reset nlp tx_out", tx_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
